// File: rtl/card_game_ctrl.sv
// Game controller for the 16-card memory game.
// Shuffles cards into a 4x4 grid, moves the cursor and runs the flip/compare/hide sequence.
module card_game_ctrl #(
    parameter int unsigned DELAY_TICKS  = 60,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Tick,
    input  logic        BtnLeft,
    input  logic        BtnRight,
    input  logic        BtnUp,
    input  logic        BtnDown,
    input  logic        BtnSel,
    input  logic        NewGame,
    input  logic [15:0] Seed,
    output logic [15:0] regCard,
    output logic [63:0] PosBus,
    output logic [3:0]  Cursor,
    output logic [15:0] Matched,
    output logic [7:0]  Moves,
    output logic        Busy,
    output logic        Win
);

    localparam int unsigned TIMER_W   = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_SHUFFLE,
        S_FIRST,
        S_SECOND,
        S_COMPARE,
        S_SHOW,
        S_WIN
    } state_t;

    state_t               state_q, state_d;
    logic [15:0][3:0]     pos_q, pos_d;
    logic [15:0][3:0]     slot_q, slot_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           first_q, first_d;
    logic [3:0]           second_q, second_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [15:0]          flipped_q, flipped_d;
    logic [15:0]          matched_q, matched_d;
    logic [7:0]           moves_q, moves_d;
    logic [3:0]           cursor_q, cursor_d;
    logic [15:0]          card_q;
    logic                 busy_q;
    logic                 win_q;

    logic [15:0]          lfsr_step;
    logic [3:0]           swap_j;
    logic [3:0]           sel_card;
    logic [15:0]          up_mask;
    logic [15:0]          sel_bit;
    logic [15:0]          pair_bits;
    logic [1:0]           row;
    logic [1:0]           col;

    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign swap_j    = lfsr_q[3:0];
    assign up_mask   = matched_q | flipped_q;
    assign sel_card  = slot_q[cursor_q];
    assign sel_bit   = 16'(1) << sel_card;
    assign pair_bits = (16'(1) << first_q) | (16'(1) << second_q);
    assign row       = cursor_q[3:2];
    assign col       = cursor_q[1:0];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_SHUFFLE;
            for (int i = 0; i < 16; i++) begin
                pos_q[i]  <= 4'(i);
                slot_q[i] <= 4'(i);
            end
            lfsr_q    <= SEED_DEFAULT;
            idx_q     <= 4'd0;
            first_q   <= 4'd0;
            second_q  <= 4'd0;
            timer_q   <= '0;
            flipped_q <= 16'h0000;
            matched_q <= 16'h0000;
            moves_q   <= 8'd0;
            cursor_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            slot_q    <= slot_d;
            lfsr_q    <= lfsr_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            second_q  <= second_d;
            timer_q   <= timer_d;
            flipped_q <= flipped_d;
            matched_q <= matched_d;
            moves_q   <= moves_d;
            cursor_q  <= cursor_d;
        end
    end

    // Status outputs registered from next-state values so they align with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            card_q <= 16'h0000;
            busy_q <= 1'b1;
            win_q  <= 1'b0;
        end else begin
            card_q <= matched_d | flipped_d;
            busy_q <= (state_d == S_SHUFFLE);
            win_q  <= (state_d == S_WIN);
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        slot_d    = slot_q;
        lfsr_d    = lfsr_q;
        idx_d     = idx_q;
        first_d   = first_q;
        second_d  = second_q;
        timer_d   = timer_q;
        flipped_d = flipped_q;
        matched_d = matched_q;
        moves_d   = moves_q;
        cursor_d  = cursor_q;

        // One cursor move per cycle, Right > Left > Down > Up
        if (state_q != S_SHUFFLE && !NewGame) begin
            if (BtnRight)     cursor_d = {row, col + 2'd1};
            else if (BtnLeft) cursor_d = {row, col - 2'd1};
            else if (BtnDown) cursor_d = {row + 2'd1, col};
            else if (BtnUp)   cursor_d = {row - 2'd1, col};
        end

        case (state_q)
            S_SHUFFLE: begin
                slot_d[idx_q]         = slot_q[swap_j];
                slot_d[swap_j]        = slot_q[idx_q];
                pos_d[slot_q[idx_q]]  = swap_j;
                pos_d[slot_q[swap_j]] = idx_q;
                lfsr_d                = lfsr_step;
                idx_d                 = idx_q + 4'd1;
                if (idx_q == 4'd15) state_d = S_FIRST;
            end
            S_FIRST: begin
                if (BtnSel && !up_mask[sel_card]) begin
                    flipped_d = flipped_q | sel_bit;
                    first_d   = sel_card;
                    state_d   = S_SECOND;
                end
            end
            S_SECOND: begin
                if (BtnSel && !up_mask[sel_card]) begin
                    flipped_d = flipped_q | sel_bit;
                    second_d  = sel_card;
                    state_d   = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
                if (first_q[2:0] == second_q[2:0]) begin
                    matched_d = matched_q | pair_bits;
                    flipped_d = flipped_q & ~pair_bits;
                    state_d   = ((matched_q | pair_bits) == 16'hFFFF) ? S_WIN : S_FIRST;
                end else begin
                    timer_d = '0;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (Tick) begin
                    if (timer_q == TIMER_W'(DELAY_TICKS - 1)) begin
                        flipped_d = flipped_q & ~pair_bits;
                        state_d   = S_FIRST;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            S_WIN: begin
            end
            default: state_d = S_SHUFFLE;
        endcase

        // Restart overrides everything except the cursor
        if (NewGame) begin
            flipped_d = 16'h0000;
            matched_d = 16'h0000;
            moves_d   = 8'd0;
            timer_d   = '0;
            lfsr_d    = (Seed == 16'h0000) ? SEED_DEFAULT : Seed;
            idx_d     = 4'd0;
            for (int i = 0; i < 16; i++) begin
                pos_d[i]  = 4'(i);
                slot_d[i] = 4'(i);
            end
            state_d   = S_SHUFFLE;
        end
    end

    assign regCard = card_q;
    assign PosBus  = pos_q;
    assign Cursor  = cursor_q;
    assign Matched = matched_q;
    assign Moves   = moves_q;
    assign Busy    = busy_q;
    assign Win     = win_q;

endmodule

// File: tb/tb_card_game_ctrl.sv
// Directed bench for card_game_ctrl with a reference shuffle model and an expected-value queue.
module tb_card_game_ctrl;

    localparam int unsigned DELAY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Tick = 1'b0;
    logic        BtnLeft = 1'b0;
    logic        BtnRight = 1'b0;
    logic        BtnUp = 1'b0;
    logic        BtnDown = 1'b0;
    logic        BtnSel = 1'b0;
    logic        NewGame = 1'b0;
    logic [15:0] Seed = 16'h0000;
    logic [15:0] regCard;
    logic [63:0] PosBus;
    logic [3:0]  Cursor;
    logic [15:0] Matched;
    logic [7:0]  Moves;
    logic        Busy;
    logic        Win;

    card_game_ctrl #(.DELAY_TICKS(DELAY), .SEED_DEFAULT(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .Tick(Tick),
        .BtnLeft(BtnLeft), .BtnRight(BtnRight), .BtnUp(BtnUp), .BtnDown(BtnDown),
        .BtnSel(BtnSel), .NewGame(NewGame), .Seed(Seed),
        .regCard(regCard), .PosBus(PosBus), .Cursor(Cursor), .Matched(Matched),
        .Moves(Moves), .Busy(Busy), .Win(Win)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          m_pos[16];
    int          m_slot[16];
    logic [3:0]  m_cursor = 4'd0;
    logic [63:0] pb_ace1;
    logic [63:0] pb_1234;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: observed %0h with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Reference shuffle: identity mapping, 16 LFSR-driven swaps
    task automatic model_shuffle(input logic [15:0] seed, output logic [63:0] pb);
        logic [15:0] s;
        int j, a, b;
        s = (seed == 16'h0000) ? 16'hACE1 : seed;
        for (int i = 0; i < 16; i++) begin
            m_pos[i]  = i;
            m_slot[i] = i;
        end
        for (int k = 0; k < 16; k++) begin
            j = int'(s[3:0]);
            a = m_slot[k];
            b = m_slot[j];
            m_slot[k] = b;
            m_slot[j] = a;
            m_pos[b]  = k;
            m_pos[a]  = j;
            s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
        end
        pb = '0;
        for (int i = 0; i < 16; i++) pb[4*i +: 4] = 4'(m_pos[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic r, input logic l, input logic dn, input logic up,
                         input logic sel, input logic ng, input logic tk);
        BtnRight = r; BtnLeft = l; BtnDown = dn; BtnUp = up;
        BtnSel = sel; NewGame = ng; Tick = tk;
        step();
        BtnRight = 0; BtnLeft = 0; BtnDown = 0; BtnUp = 0;
        BtnSel = 0; NewGame = 0; Tick = 0;
        if (!ng) begin
            if (r)       m_cursor = {m_cursor[3:2], m_cursor[1:0] + 2'd1};
            else if (l)  m_cursor = {m_cursor[3:2], m_cursor[1:0] - 2'd1};
            else if (dn) m_cursor = {m_cursor[3:2] + 2'd1, m_cursor[1:0]};
            else if (up) m_cursor = {m_cursor[3:2] - 2'd1, m_cursor[1:0]};
        end
    endtask

    task automatic move_to(input logic [3:0] tgt);
        while (m_cursor[1:0] != tgt[1:0]) press(1, 0, 0, 0, 0, 0, 0);
        while (m_cursor[3:2] != tgt[3:2]) press(0, 0, 1, 0, 0, 0, 0);
        push("cursor_nav", 64'(tgt));
        pop_check(64'(Cursor));
    endtask

    task automatic select_card(input int c);
        move_to(4'(m_pos[c]));
        press(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic new_game(input logic [15:0] s);
        Seed = s;
        press(0, 0, 0, 0, 0, 1, 0);
        push("ng_busy", 64'd1);
        push("ng_regcard", 64'd0);
        push("ng_moves", 64'd0);
        push("ng_win", 64'd0);
        pop_check(64'(Busy));
        pop_check(64'(regCard));
        pop_check(64'(Moves));
        pop_check(64'(Win));
    endtask

    // Shuffle takes 16 cycles after reset release or NewGame
    task automatic wait_shuffle(input logic [63:0] exp_pb, input string tag);
        logic [15:0] mask;
        for (int i = 0; i < 15; i++) step();
        push({tag, "_busy15"}, 64'd1);
        pop_check(64'(Busy));
        step();
        push({tag, "_busy16"}, 64'd0);
        push({tag, "_posbus"}, exp_pb);
        pop_check(64'(Busy));
        pop_check(PosBus);
        mask = 16'h0000;
        for (int i = 0; i < 16; i++) mask[PosBus[4*i +: 4]] = 1'b1;
        push({tag, "_perm"}, 64'hFFFF);
        pop_check(64'(mask));
    endtask

    initial begin
        int c, d;
        logic [63:0] pb_tmp;
        model_shuffle(16'hACE1, pb_ace1);
        model_shuffle(16'h1234, pb_1234);

        // 1: reset state and initial shuffle
        #12;
        push("rst_busy", 64'd1);
        push("rst_regcard", 64'd0);
        push("rst_cursor", 64'd0);
        push("rst_moves", 64'd0);
        push("rst_win", 64'd0);
        push("rst_matched", 64'd0);
        push("rst_posbus", 64'hFEDC_BA98_7654_3210);
        pop_check(64'(Busy));
        pop_check(64'(regCard));
        pop_check(64'(Cursor));
        pop_check(64'(Moves));
        pop_check(64'(Win));
        pop_check(64'(Matched));
        pop_check(PosBus);
        step();
        rst_n = 1'b1;
        wait_shuffle(pb_ace1, "boot");

        // 2: seed handling
        new_game(16'h0000);
        wait_shuffle(pb_ace1, "seed0");
        new_game(16'hACE1);
        wait_shuffle(pb_ace1, "seedace1");
        new_game(16'h1234);
        model_shuffle(16'h1234, pb_tmp);
        wait_shuffle(pb_1234, "seed1234");

        // 3: matching pair 2/10
        select_card(2);
        select_card(10);
        step();
        push("pair_moves", 64'd1);
        push("pair_matched", 64'h0404);
        push("pair_regcard", 64'h0404);
        pop_check(64'(Moves));
        pop_check(64'(Matched));
        pop_check(64'(regCard));

        // 4: mismatch 0/1 held for DELAY ticks
        new_game(16'h1234);
        wait_shuffle(pb_1234, "show_ng");
        select_card(0);
        select_card(1);
        step();
        push("show_flip", 64'h0003);
        push("show_moves", 64'd1);
        pop_check(64'(regCard));
        pop_check(64'(Moves));
        press(0, 0, 0, 0, 0, 0, 1);
        push("show_tick1", 64'h0003);
        pop_check(64'(regCard));
        press(0, 0, 0, 0, 0, 0, 1);
        push("show_tick2", 64'h0003);
        pop_check(64'(regCard));
        select_card(5);
        push("show_sel_ignored", 64'h0003);
        pop_check(64'(regCard));
        press(0, 0, 0, 0, 0, 0, 1);
        push("show_tick3", 64'h0000);
        push("show_moves_end", 64'd1);
        pop_check(64'(regCard));
        pop_check(64'(Moves));

        // 5: cursor wrap and priority, double select
        move_to(4'd3);
        press(1, 0, 0, 0, 0, 0, 0);
        push("wrap_right", 64'd0);
        pop_check(64'(Cursor));
        move_to(4'd12);
        press(0, 0, 1, 0, 0, 0, 0);
        push("wrap_down", 64'd0);
        pop_check(64'(Cursor));
        move_to(4'd5);
        press(1, 0, 0, 1, 0, 0, 0);
        push("prio_right_up", 64'd6);
        pop_check(64'(Cursor));
        c = m_slot[6];
        press(0, 0, 0, 0, 1, 0, 0);
        push("dsel_first", 64'(16'(1) << c));
        pop_check(64'(regCard));
        press(0, 0, 0, 0, 1, 0, 0);
        push("dsel_second", 64'(16'(1) << c));
        pop_check(64'(regCard));
        d = (c + 1) % 16;
        select_card(d);
        step();
        push("dsel_cmp_moves", 64'd2);
        push("dsel_cmp_card", 64'((16'(1) << c) | (16'(1) << d)));
        pop_check(64'(Moves));
        pop_check(64'(regCard));

        // 6: NewGame aborts SHOW, then clear the board
        press(0, 0, 0, 0, 0, 0, 1);
        new_game(16'h0000);
        model_shuffle(16'h0000, pb_tmp);
        wait_shuffle(pb_ace1, "win_ng");
        for (int p = 0; p < 8; p++) begin
            select_card(p);
            select_card(p + 8);
            step();
            if (p == 6) begin
                push("win_not_yet", 64'd0);
                pop_check(64'(Win));
            end
        end
        push("win_flag", 64'd1);
        push("win_regcard", 64'hFFFF);
        push("win_matched", 64'hFFFF);
        push("win_moves", 64'd8);
        pop_check(64'(Win));
        pop_check(64'(regCard));
        pop_check(64'(Matched));
        pop_check(64'(Moves));
        press(0, 0, 0, 0, 1, 0, 0);
        push("win_hold", 64'd1);
        pop_check(64'(Win));
        new_game(16'h1234);

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
